seq_detect_param: RTL
=====================

// Module: seq_detect_param
// PURPOSE
//  Parametrised serial bit-pattern detector, the successor to the fixed 3-bit "101" detector FSM.
//  - Pattern width and match-counter width are parameters; the pattern is runtime-loadable.
//  - Adds input qualification, an overlap/non-overlap mode and a saturating match counter.
//  - Sits on a serial data path; o feeds event logic, match_cnt feeds status readback.
// PARAMETERS
//  PAT_W        3         pattern length in bits, 2..16
//  PAT_DEFAULT  3'b101    pattern in force after reset (PAT_W bits; MSB = oldest bit)
//  CNT_W        8         match counter width, >=2
// PORTS
//  ck         input   1      clock, all state on rising edge
//  r          input   1      asynchronous active-low reset (0 = reset)
//  i          input   1      serial data bit
//  i_vld      input   1      i is sampled only when 1
//  overlap    input   1      1 = overlapping matches allowed, 0 = window restarts after a match
//  pat        input   PAT_W  new pattern (MSB = first/oldest bit)
//  pat_load   input   1      1-cycle pulse: capture pat, flush window
//  cnt_clr    input   1      clear match counter
//  o          output  1      registered match pulse, 1 cycle wide
//  match_cnt  output  CNT_W  saturating count of matches
//  cnt_sat    output  1      1 while match_cnt == all ones
// BEHAVIOUR
//  - Reset (r=0, async): pat_q=PAT_DEFAULT, hist=0, fill=0, state=FILL, o=0, match_cnt=0, cnt_sat=0.
//  - Window: hist[PAT_W-1:0] shifts left on each i_vld, new bit into LSB. fill counts valid bits,
//    0..PAT_W, saturating at PAT_W.
//  - FSM, 2 states:
//      FILL:  fill < PAT_W. Go to ARMED when the shift makes fill == PAT_W.
//      ARMED: window full.
//  - Match: i_vld=1 and {hist[PAT_W-2:0], i} == pat_q and (fill_next == PAT_W).
//      o=1 in the cycle after the sampling edge (latency 1 clock, registered).
//      Otherwise o=0; no stretching.
//  - After a match:
//      overlap=1: stay ARMED, window keeps shifting.
//      overlap=0: fill<=0, hist<=0, state<=FILL; the next PAT_W bits must all be new.
//  - overlap is sampled with the completing bit; changing it mid-stream is legal.
//  - i_vld=0: hist, fill, state hold; o<=0.
//  - pat_load=1: pat_q<=pat, hist<=0, fill<=0, state<=FILL, o<=0.
//      If i_vld is also 1 that bit is discarded: load wins over data, no match is evaluated.
//  - Counter: +1 per match, saturating at 2^CNT_W-1; cnt_sat is a registered compare.
//      cnt_clr alone: match_cnt<=0.
//      cnt_clr with a match in the same cycle: match_cnt<=1 (clear, then count).
//  - pat_load does not touch match_cnt.
//  - Reset asserted mid-stream aborts everything immediately. First sample is accepted on the
//    first rising edge with r=1.
//  - No X propagation: i is ignored when i_vld=0.
// STRUCTURE
//  - Package seq_det_pkg: state enum {FILL, ARMED}; the PAT_W range limits as localparams.
//  - Sub-module seq_det_window #(PAT_W): hist shift register and fill counter, with flush and
//    shift inputs. Outputs next_window, fill_next and full_next.
//  - Top: FSM, match compare, output register, counter.
// TESTING (PAT_W=3, pat=101, CNT_W=8 unless stated)
//  1. Reset release, i_vld=1, bits 1,0,1,0,1, overlap=1
//     -> o=1 the cycle after bits 3 and 5; match_cnt=2.
//  2. Same stream, overlap=0
//     -> o=1 only after bit 3; bits 4,5 refill to fill=2, no match; match_cnt=1.
//  3. Bits 1,0 with i_vld, 3 idle cycles (i toggling), then 1
//     -> single o pulse after the final bit; no pulse during idle.
//  4. Feed 1,0; pulse pat_load with pat=3'b110 together with i_vld, i=1; then feed 1,1,0
//     -> no match from the old pattern; o=1 after the final 0.
//  5. CNT_W=2: feed 5 overlapping matches (1,0,1,0,1,0,1,0,1,0,1)
//     -> match_cnt sticks at 3, cnt_sat=1. Then cnt_clr coincident with a match -> match_cnt=1.
//  6. Assert r=0 asynchronously between edges after bits 1,0
//     -> o and match_cnt go 0 at once. After release, feeding 1 gives no match; 1,0,1 matches.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and limits for the parametrised serial pattern detector.
package seq_det_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      ARMED = 1'b1
   } state_t;

   localparam int PAT_W_MIN = 2;
   localparam int PAT_W_MAX = 16;

endpackage

// File: rtl/seq_det_window.sv
// Sliding bit window with a saturating fill count; exposes the post-shift
// window and fill so the top can decide on a match in the same cycle.
module seq_det_window
   import seq_det_pkg::*;
#(
   parameter int  PAT_W  = 3,
   localparam int FILL_W = $clog2(PAT_W + 1)
) (
   input  logic              ck,
   input  logic              r,
   input  logic              shift,
   input  logic              flush,
   input  logic              bit_in,
   output logic [PAT_W-1:0]  next_window,
   output logic [FILL_W-1:0] fill_next,
   output logic              full_next
);

   if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
      $error("seq_det_window: PAT_W out of range");
   end

   // Only the newest PAT_W-1 bits are kept: the oldest bit of a full window
   // is never compared again once the next bit arrives.
   logic [PAT_W-2:0]  hist;
   logic [FILL_W-1:0] fill;

   assign next_window = {hist, bit_in};
   assign fill_next   = (fill == FILL_W'(PAT_W)) ? fill : fill + 1'b1;
   assign full_next   = (fill_next == FILL_W'(PAT_W));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge ck or negedge r) begin
      if (!r) begin
         hist <= '0;
         fill <= '0;
      end else if (flush) begin
         hist <= '0;
         fill <= '0;
      end else if (shift) begin
         hist <= next_window[PAT_W-2:0];
         fill <= fill_next;
      end
   end

endmodule

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with loadable pattern, overlap control and a
// saturating match counter.
module seq_detect_param
   import seq_det_pkg::*;
#(
   parameter int               PAT_W       = 3,
   parameter logic [PAT_W-1:0] PAT_DEFAULT = 3'b101,
   parameter int               CNT_W       = 8
) (
   input  logic             ck,
   input  logic             r,
   input  logic             i,
   input  logic             i_vld,
   input  logic             overlap,
   input  logic [PAT_W-1:0] pat,
   input  logic             pat_load,
   input  logic             cnt_clr,
   output logic             o,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   localparam int FILL_W = $clog2(PAT_W + 1);

   state_t             state;
   logic [PAT_W-1:0]   pat_q;
   logic [PAT_W-1:0]   next_window;
   logic [FILL_W-1:0]  fill_next;
   logic               full_next;
   logic               shift;
   logic               match;
   logic               flush;
   logic [CNT_W-1:0]   cnt_next;

   // A load discards any coincident data bit, so it also suppresses the match.
   assign shift = i_vld & ~pat_load;
   assign match = shift && (fill_next == FILL_W'(PAT_W)) && (next_window == pat_q);
   assign flush = pat_load | (match & ~overlap);

   seq_det_window #(.PAT_W(PAT_W)) u_window (
      .ck          (ck),
      .r           (r),
      .shift       (shift),
      .flush       (flush),
      .bit_in      (i),
      .next_window (next_window),
      .fill_next   (fill_next),
      .full_next   (full_next)
   );

   // NOTE: give every always_comb output a default first so no path leaves it
   // unassigned, which would infer a latch.
   always_comb begin
      cnt_next = match_cnt;
      if (cnt_clr)
         cnt_next = match ? CNT_W'(1) : '0;
      else if (match && !(&match_cnt))
         cnt_next = match_cnt + 1'b1;
   end

   always_ff @(posedge ck or negedge r) begin
      if (!r) begin
         state     <= FILL;
         pat_q     <= PAT_DEFAULT;
         o         <= 1'b0;
         match_cnt <= '0;
         cnt_sat   <= 1'b0;
      end else begin
         o         <= match;
         match_cnt <= cnt_next;
         cnt_sat   <= &cnt_next;
         if (pat_load) begin
            pat_q <= pat;
            state <= FILL;
         end else if (shift) begin
            case (state)
               FILL:    if (full_next && !flush) state <= ARMED;
               ARMED:   if (flush)               state <= FILL;
               default: state <= FILL;
            endcase
         end
      end
   end

endmodule
